// File: rtl/rd_responder_pkg.sv
// Shared types for the read responder: FSM states and wait-counter width.
package rd_resp_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_DLY
    } state_e;

endpackage

// File: rtl/rd_responder_if.sv
// Initiator <-> responder read bus; write port exists only with RD_RESP_WRITE_EN.
interface rd_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              ws;
    logic [DATA_W-1:0] rdata;
    logic              rdata_vld;
    logic              err;
`ifdef RD_RESP_WRITE_EN
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd, addr, wr_en, wr_addr, wr_data,
        input  ws, rdata, rdata_vld, err
    );
    modport slave (
        input  rd, addr, wr_en, wr_addr, wr_data,
        output ws, rdata, rdata_vld, err
    );
`else
    modport master (
        output rd, addr,
        input  ws, rdata, rdata_vld, err
    );
    modport slave (
        input  rd, addr,
        output ws, rdata, rdata_vld, err
    );
`endif
endinterface

// File: rtl/rd_responder_mem.sv
// rd_resp_mem: word i resets to i; read port is combinational, so a same-edge
// write is seen by the registered reader as old data. Write port: RD_RESP_WRITE_EN.
module rd_resp_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef RD_RESP_WRITE_EN
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`endif
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
`ifdef RD_RESP_WRITE_EN
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/rd_responder.sv
// Wait-stated read responder: IDLE -> DLY/READ alternation -> final DLY with data.
// Optional write port to storage under RD_RESP_WRITE_EN.
module rd_responder
    import rd_resp_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int WAIT_STATES = 2
) (
    input logic            clk,
    input logic            reset,
    rd_responder_if.slave  bus
);
    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ws_q, ws_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // With zero wait states the data load happens on the T0 edge itself,
    // before addr_q is valid, so idle reads look at the live bus address.
    assign mem_addr = (state_q == R_IDLE) ? bus.addr : addr_q;

    rd_resp_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
`ifdef RD_RESP_WRITE_EN
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
`endif
        .rd_addr (mem_addr),
        .rd_data (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        ws_d    = 1'b0;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (bus.rd) begin
                    addr_d  = bus.addr;
                    cnt_d   = WS_INIT;
                    state_d = R_DLY;
                    ws_d    = (WS_INIT != '0);
                end
            end
            R_READ: begin
                if (bus.rd) begin
                    state_d = R_DLY;
                    ws_d    = (cnt_q != '0);
                end else begin
                    state_d = R_IDLE;
                    err_d   = 1'b1;
                end
            end
            R_DLY: begin
                if (!bus.rd) begin
                    state_d = R_IDLE;
                    err_d   = 1'b1;
                end else if (ws_q) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = R_READ;
                end else begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
        if (state_d == R_DLY && cnt_d == '0) begin
            rdata_d = mem_rdata;
            vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ws_q    <= 1'b0;
            rdata_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ws_q    <= ws_d;
            rdata_q <= rdata_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign bus.ws        = ws_q;
    assign bus.rdata     = rdata_q;
    assign bus.rdata_vld = vld_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_rd_responder.sv
// Scoreboarded bench: dut_a has two wait states, dut_b has none.
module tb_rd_responder;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    rd_responder_if #(.DATA_W(8), .ADDR_W(4)) ia ();
    rd_responder_if #(.DATA_W(8), .ADDR_W(4)) ib ();

    rd_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    rd_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_STATES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop one expected word per rdata_vld pulse.
    always @(negedge clk) begin
        if (ia.rdata_vld === 1'b1) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_vld: got rdata %0h expected none",
                         ia.rdata);
            end else begin
                automatic logic [7:0] e = qa.pop_front();
                if (ia.rdata !== e) begin
                    bad++;
                    $display("FAIL a_rdata: got %0h expected %0h", ia.rdata, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ib.rdata_vld === 1'b1) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_vld: got rdata %0h expected none",
                         ib.rdata);
            end else begin
                automatic logic [7:0] e = qb.pop_front();
                if (ib.rdata !== e) begin
                    bad++;
                    $display("FAIL b_rdata: got %0h expected %0h", ib.rdata, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input logic r, input logic [3:0] a);
        if (b) begin
            ib.rd   = r;
            ib.addr = a;
        end else begin
            ia.rd   = r;
            ia.addr = a;
        end
    endtask

    function automatic logic [10:0] outs(input bit b);
        // {err, vld, ws, rdata}
        if (b) return {ib.err, ib.rdata_vld, ib.ws, ib.rdata};
        return {ia.err, ia.rdata_vld, ia.ws, ia.rdata};
    endfunction

    // Full read; addr is scrambled after T0, then one rd=0 gap cycle.
    // wr_k >= 0 writes wr_v to the read word during cycle wr_k (dut_a only).
    task automatic do_read(input bit b, input logic [3:0] a, input int wsn,
                           input logic [7:0] exp, input int wr_k,
                           input logic [7:0] wr_v);
        int len;
        logic [10:0] o;
        len = 2 * (wsn + 1);
        if (b) qb.push_back(exp);
        else   qa.push_back(exp);
        for (int k = 0; k < len; k++) begin
            drive(b, 1'b1, (k == 0) ? a : (a ^ 4'hF));
`ifdef RD_RESP_WRITE_EN
            if (!b) begin
                ia.wr_en   = (k == wr_k);
                ia.wr_addr = a;
                ia.wr_data = wr_v;
            end
`else
            if (wr_k > len) $display("note: write unsupported %0h", wr_v);
`endif
            if (k > 0) begin
                o = outs(b);
                chk($sformatf("ws_k%0d", k), o[8],
                    ((k % 2 == 1) && (k < 2 * wsn)));
                chk($sformatf("err_k%0d", k), o[10], 1'b0);
                if (k == len - 1) chk("vld_final", o[9], 1'b1);
            end
            step();
        end
        drive(b, 1'b0, a);
`ifdef RD_RESP_WRITE_EN
        ia.wr_en = 1'b0;
`endif
        o = outs(b);
        chk("gap_vld", o[9], 1'b0);
        chk("gap_err", o[10], 1'b0);
        chk("gap_ws", o[8], 1'b0);
        chk("gap_hold", o[7:0], exp);
        step();
    endtask

    initial begin
        logic [10:0] o;
        reset = 1'b1;
        drive(0, 1'b0, 4'h0);
        drive(1, 1'b0, 4'h0);
`ifdef RD_RESP_WRITE_EN
        ia.wr_en = 1'b0; ia.wr_addr = '0; ia.wr_data = '0;
        ib.wr_en = 1'b0; ib.wr_addr = '0; ib.wr_data = '0;
`endif
        step();
        step();
        chk("rst_a", outs(0), 11'h0);
        chk("rst_b", outs(1), 11'h0);
        reset = 1'b0;
        step();

        do_read(0, 4'h3, 2, 8'h03, -1, 8'h00);
        do_read(0, 4'h1, 2, 8'h01, -1, 8'h00);
        do_read(0, 4'h2, 2, 8'h02, -1, 8'h00);

        // abort: rd dropped in T2
        drive(0, 1'b1, 4'h5); step();
        chk("ab_ws_t1", ia.ws, 1'b1);
        drive(0, 1'b1, 4'hA); step();
        drive(0, 1'b0, 4'h0); step();
        o = outs(0);
        chk("ab_err_t3", o[10], 1'b1);
        chk("ab_ws_t3", o[8], 1'b0);
        chk("ab_rdata_t3", o[7:0], 8'h02);
        step();
        chk("ab_err_t4", ia.err, 1'b0);

        // reset during T3 of a read
        drive(0, 1'b1, 4'h7); step();
        step();
        step();
        reset = 1'b1;
        drive(0, 1'b0, 4'h0);
        step();
        chk("mid_rst_outs", outs(0), 11'h0);
        reset = 1'b0;
        step();
        do_read(0, 4'h6, 2, 8'h06, -1, 8'h00);

        do_read(1, 4'h9, 0, 8'h09, -1, 8'h00);
        do_read(1, 4'hF, 0, 8'h0F, -1, 8'h00);
        do_read(1, 4'h0, 0, 8'h00, -1, 8'h00);

`ifdef RD_RESP_WRITE_EN
        ia.wr_en = 1'b1; ia.wr_addr = 4'h4; ia.wr_data = 8'hA5;
        step();
        ia.wr_en = 1'b0;
        do_read(0, 4'h4, 2, 8'hA5, -1, 8'h00);
        do_read(0, 4'h4, 2, 8'hA5, 4, 8'h5A);
        do_read(0, 4'h4, 2, 8'h5A, -1, 8'h00);
`endif

        step();
        step();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
